// File: rtl/multi_spi_sensor_poller.sv
// Round-robin read-only SPI poller: shared SCLK, per-channel CS_n/MISO,
// results latched per channel, one-shot or continuous sweeps.
module multi_spi_sensor_poller #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 16,
  parameter int CLK_DIV     = 25,
  parameter int POLL_PERIOD = 11_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     mode_cont,
  input  logic [NUM_CH-1:0]        miso,
  output logic                     sclk,
  output logic [NUM_CH-1:0]        cs_n,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        data_valid,
  output logic                     new_data,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW  = $clog2(DATA_W);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, STORE, WAIT
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [BW-1:0]            bit_q;
  logic [CHW-1:0]           ch_q;
  logic [WW-1:0]            wait_q;
  logic [DATA_W-1:0]        sh_q;
  logic                     sclk_q;
  logic [NUM_CH-1:0]        cs_n_q;
  logic [NUM_CH*DATA_W-1:0] data_q;
  logic [NUM_CH-1:0]        valid_q;
  logic                     new_q;
  logic                     done_q;
  logic                     busy_q;

  logic           cnt_done_d;
  logic           bit_last_d;
  logic           ch_last_d;
  logic           wait_done_d;
  logic [CHW-1:0] ch_d;

  always_comb begin
    cnt_done_d  = (cnt_q == CW'(CLK_DIV - 1));
    bit_last_d  = (bit_q == BW'(DATA_W - 1));
    ch_last_d   = (ch_q == CHW'(NUM_CH - 1));
    wait_done_d = (wait_q == WW'(POLL_PERIOD - 1));
    ch_d        = ch_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      wait_q  <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= '1;
      data_q  <= '0;
      valid_q <= '0;
      new_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (!enable) begin
      // Abort: partial frame dropped, latched results kept
      state_q <= IDLE;
      sclk_q  <= 1'b0;
      cs_n_q  <= '1;
      new_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      new_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETUP;
            ch_q    <= '0;
            cnt_q   <= '0;
            cs_n_q  <= ~NUM_CH'(1);
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_done_d) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SHIFT: begin
          if (sclk_q && cnt_q == '0) begin
            sh_q <= {sh_q[DATA_W-2:0], miso[ch_q]};
          end
          if (cnt_done_d) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_last_d) begin
                state_q <= HOLD;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_done_d) begin
            state_q <= STORE;
            cnt_q   <= '0;
            cs_n_q  <= '1;
            data_q[ch_q*DATA_W +: DATA_W] <= sh_q;
            valid_q[ch_q] <= 1'b1;
            new_q   <= 1'b1;
            done_q  <= ch_last_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STORE: begin
          if (!ch_last_d) begin
            state_q <= SETUP;
            ch_q    <= ch_d;
            cs_n_q  <= ~(NUM_CH'(1) << ch_d);
          end else if (mode_cont) begin
            state_q <= WAIT;
            wait_q  <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (!mode_cont) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (wait_done_d) begin
            state_q <= SETUP;
            ch_q    <= '0;
            cnt_q   <= '0;
            cs_n_q  <= ~NUM_CH'(1);
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sclk       = sclk_q;
  assign cs_n       = cs_n_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign new_data   = new_q;
  assign frame_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_multi_spi_sensor_poller.sv
// Directed bench for multi_spi_sensor_poller with a 2-channel
// SPI sensor model shifting MSB first on SCLK falling edges.
module tb_multi_spi_sensor_poller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic        mode_cont;
  logic [1:0]  miso;
  logic        sclk;
  logic [1:0]  cs_n;
  logic [31:0] data_out;
  logic [1:0]  data_valid;
  logic        new_data;
  logic        frame_done;
  logic        busy;

  multi_spi_sensor_poller #(
    .NUM_CH(2), .DATA_W(16), .CLK_DIV(2), .POLL_PERIOD(100)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .start(start), .mode_cont(mode_cont), .miso(miso),
    .sclk(sclk), .cs_n(cs_n), .data_out(data_out),
    .data_valid(data_valid), .new_data(new_data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sensor model
  logic [15:0] pat [2];
  int          bc  [2];

  initial begin
    bc[0] = 0;
    bc[1] = 0;
  end

  always @(negedge sclk)
    for (int k = 0; k < 2; k++)
      if (!cs_n[k]) bc[k]++;

  always @(cs_n)
    for (int k = 0; k < 2; k++)
      if (cs_n[k]) bc[k] = 0;

  always_comb begin
    miso = 2'b00;
    for (int k = 0; k < 2; k++)
      if (!cs_n[k] && bc[k] < 16) miso[k] = pat[k][15 - bc[k]];
  end

  // Cycle counter and monitors
  int cyc = 0;
  int t0  = 0;
  int nd_q[$];
  int fd_q[$];
  int viol     = 0;
  int cs0_low  = 0;
  int rises0   = 0;
  int last_r   = -1;
  int per_min  = 1000;
  int per_max  = 0;
  logic prev_sclk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (new_data)   nd_q.push_back(cyc - t0);
      if (frame_done) fd_q.push_back(cyc - t0);
      if (cs_n == 2'b00) viol++;
      if (cs_n == 2'b11 && sclk) viol++;
      if (!cs_n[0]) begin
        cs0_low++;
        if (sclk && !prev_sclk) begin
          rises0++;
          if (last_r >= 0) begin
            if (cyc - last_r < per_min) per_min = cyc - last_r;
            if (cyc - last_r > per_max) per_max = cyc - last_r;
          end
          last_r = cyc;
        end
      end
    end
    prev_sclk = sclk;
  end

  task automatic clr_mon();
    nd_q.delete();
    fd_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(string tag, int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_fd(string tag, int cnt, int lim);
    int n = 0;
    while (fd_q.size() < cnt && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (fd_q.size() < cnt) check({tag, "_timeout"}, fd_q.size(), cnt);
  endtask

  logic [15:0] bpat [3];
  logic [31:0] bexp [3];

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    start = 1'b0;
    mode_cont = 1'b0;
    pat[0] = 16'hA5C3;
    pat[1] = 16'h1234;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_sclk", sclk, 0);
    check("rst_cs", cs_n, 2'b11);
    check("rst_data", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_new", new_data, 0);
    check("rst_fd", frame_done, 0);
    check("rst_busy", busy, 0);

    // One-shot sweep with timing measurement
    clr_mon();
    cs0_low = 0;
    rises0 = 0;
    pulse_start();
    check("busy_run", busy, 1);
    wait_idle("oneshot", 400);
    check("os_data", data_out, 32'h1234_A5C3);
    check("os_valid", data_valid, 2'b11);
    check("os_nd_cnt", nd_q.size(), 2);
    if (nd_q.size() == 2) begin
      check("os_nd0", nd_q[0], 69);
      check("os_nd1", nd_q[1], 138);
    end
    check("os_fd_cnt", fd_q.size(), 1);
    if (fd_q.size() == 1) check("os_fd", fd_q[0], 138);
    check("os_busy", busy, 0);
    check("cs0_low", cs0_low, 68);
    check("sclk_rises", rises0, 16);
    check("per_min", per_min, 4);
    check("per_max", per_max, 4);

    // Continuous mode
    clr_mon();
    mode_cont = 1'b1;
    pulse_start();
    wait_fd("cont1", 1, 400);
    pat[0] = 16'hFFFF;
    repeat (50) @(negedge clk);
    check("cont_wait_busy", busy, 1);
    wait_fd("cont2", 2, 600);
    if (fd_q.size() >= 2)
      check("cont_period", fd_q[1] - fd_q[0], 238);
    check("cont_data", data_out, 32'h1234_FFFF);
    repeat (10) @(negedge clk);
    mode_cont = 1'b0;
    @(negedge clk);
    check("cont_stop", busy, 0);

    // Abort during ch1 bit 7
    pat[1] = 16'h0F0F;
    clr_mon();
    pulse_start();
    begin
      int n = 0;
      while (!(cs_n[1] == 1'b0 && bc[1] == 7) && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) check("abort_timeout", n, 0);
    end
    enable = 1'b0;
    @(negedge clk);
    check("abort_cs", cs_n, 2'b11);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_ch1", data_out[31:16], 16'h1234);
    check("abort_valid", data_valid, 2'b11);
    enable = 1'b1;
    @(negedge clk);

    // Reset mid-SHIFT
    pulse_start();
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_data", data_out, 0);
    check("mrst_valid", data_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cs", cs_n, 2'b11);
    reset = 1'b0;
    @(negedge clk);

    // Start while busy
    pat[0] = 16'hA5C3;
    pat[1] = 16'h1234;
    clr_mon();
    pulse_start();
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start", 400);
    repeat (200) @(negedge clk);
    check("busy_start_fd", fd_q.size(), 1);
    check("busy_start_idle", busy, 0);

    // Boundary patterns
    bpat[0] = 16'h0000; bexp[0] = 32'h0000_0000;
    bpat[1] = 16'hFFFF; bexp[1] = 32'hFFFF_FFFF;
    bpat[2] = 16'h8001; bexp[2] = 32'h8001_8001;
    for (int i = 0; i < 3; i++) begin
      pat[0] = bpat[i];
      pat[1] = bpat[i];
      pulse_start();
      wait_idle("bnd", 400);
      check($sformatf("bnd%0d", i), data_out, bexp[i]);
    end

    check("invariants", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
